// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, default latencies and
// the busy-counter width helper.
package md_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'b000,
    MD_MULTU = 3'b001,
    MD_DIV   = 3'b010,
    MD_DIVU  = 3'b011,
    MD_MTHI  = 3'b100,
    MD_MTLO  = 3'b101
  } md_op_e;

  localparam int unsigned MdMultCyclesDefault = 5;
  localparam int unsigned MdDivCyclesDefault  = 10;

  // Bits needed to hold the larger of the two latencies.
  function automatic int unsigned md_cnt_width(input int unsigned mult_cycles,
                                               input int unsigned div_cycles);
    int unsigned max_lat;
    max_lat = (mult_cycles > div_cycles) ? mult_cycles : div_cycles;
    return $clog2(max_lat + 1);
  endfunction

endpackage

// File: rtl/md_core.sv
// Combinational datapath: signed/unsigned 32x32 multiply and divide with corner cases.
module md_core
  import md_pkg::*;
(
  input  logic [2:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] res_hi_o,
  output logic [31:0] res_lo_o,
  output logic        divzero_o
);

  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic        [31:0] mag_a, mag_b, div_b;
  logic        [31:0] q_mag, r_mag;
  logic        [31:0] q_u, r_u;
  logic               neg_q, neg_r;

  // Signed division works on magnitudes; the overflow case 0x80000000 / -1 falls out as
  // quotient 0x80000000, remainder 0 because the magnitude of 0x80000000 is itself.
  always_comb begin
    prod_s = $signed({{32{a_i[31]}}, a_i}) * $signed({{32{b_i[31]}}, b_i});
    prod_u = {32'h0, a_i} * {32'h0, b_i};
    divzero_o = (b_i == 32'h0);
    div_b  = divzero_o ? 32'h1 : b_i;  // keep the divider defined; result is discarded
    mag_a  = a_i[31] ? (~a_i + 32'h1) : a_i;
    mag_b  = div_b[31] ? (~div_b + 32'h1) : div_b;
    q_mag  = mag_a / mag_b;
    r_mag  = mag_a % mag_b;
    q_u    = a_i / div_b;
    r_u    = a_i % div_b;
    neg_q  = a_i[31] ^ div_b[31];
    neg_r  = a_i[31];
  end

  // Select the result pair for the requested op.
  always_comb begin
    res_hi_o = 32'h0;
    res_lo_o = 32'h0;
    unique case (op_i)
      MD_MULT: begin
        res_hi_o = prod_s[63:32];
        res_lo_o = prod_s[31:0];
      end
      MD_MULTU: begin
        res_hi_o = prod_u[63:32];
        res_lo_o = prod_u[31:0];
      end
      MD_DIV: begin
        res_lo_o = neg_q ? (~q_mag + 32'h1) : q_mag;
        res_hi_o = neg_r ? (~r_mag + 32'h1) : r_mag;
      end
      MD_DIVU: begin
        res_lo_o = q_u;
        res_hi_o = r_u;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mult_div_unit.sv
// Execute-stage multiply/divide unit: fixed-latency MULT/DIV with HI/LO commit at the
// end of the busy period, and single-cycle MTHI/MTLO.
module mult_div_unit
  import md_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MdMultCyclesDefault,
  parameter int unsigned DIV_CYCLES  = MdDivCyclesDefault
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned CntW = md_cnt_width(MULT_CYCLES, DIV_CYCLES);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic            pend_dz_q, pend_dz_d;
  logic [31:0]     hi_q, hi_d, lo_q, lo_d;
  logic            busy_q, busy_d;
  logic [31:0]     res_hi, res_lo;
  logic            divzero;

  md_core u_md_core (
    .op_i      (op),
    .a_i       (a),
    .b_i       (b),
    .res_hi_o  (res_hi),
    .res_lo_o  (res_lo),
    .divzero_o (divzero)
  );

  // Next state: count down while running and commit on the last cycle; accept only when idle.
  always_comb begin
    cnt_d     = cnt_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_dz_d = pend_dz_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    if (cnt_q != '0) begin
      if (cnt_q == CntW'(1)) begin
        cnt_d = '0;
        if (!pend_dz_q) begin
          hi_d = pend_hi_q;
          lo_d = pend_lo_q;
        end
      end else begin
        cnt_d = cnt_q - CntW'(1);
      end
    end else if (start) begin
      unique case (op)
        MD_MULT, MD_MULTU: begin
          cnt_d     = CntW'(MULT_CYCLES);
          pend_hi_d = res_hi;
          pend_lo_d = res_lo;
          pend_dz_d = 1'b0;
        end
        MD_DIV, MD_DIVU: begin
          cnt_d     = CntW'(DIV_CYCLES);
          pend_hi_d = res_hi;
          pend_lo_d = res_lo;
          pend_dz_d = divzero;  // HI/LO keep their value on divide by zero
        end
        MD_MTHI: hi_d = a;
        MD_MTLO: lo_d = a;
        default: ;
      endcase
    end
    busy_d = (cnt_d != '0);
  end

  // State registers; reset aborts any in-flight operation.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q     <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pend_dz_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_dz_q <= pend_dz_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
    end
  end

  assign busy = busy_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: the driver pushes expected HI/LO and busy length
// computed with plain arithmetic; a negedge monitor pops and compares.
module tb_mult_div_unit;

  localparam int unsigned MultN = 5;
  localparam int unsigned DivN  = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'b0;
  logic [31:0] a = 32'h0;
  logic [31:0] b = 32'h0;
  logic        busy;
  logic [31:0] hi, lo;

  mult_div_unit #(
    .MULT_CYCLES (MultN),
    .DIV_CYCLES  (DivN)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned cyc;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] old_hi;
    logic [31:0] old_lo;
    string       name;
  } exp_t;

  exp_t        sb_q[$];
  int          chk_cnt = 0;
  int          pass_cnt = 0;
  logic [31:0] m_hi = 32'h0;
  logic [31:0] m_lo = 32'h0;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d want %0d", name, act, exp);
  endtask

  // Reference model from the arithmetic definitions.
  function automatic exp_t model(input logic [2:0] o, input logic [31:0] x,
                                 input logic [31:0] y, input logic [31:0] h,
                                 input logic [31:0] l);
    exp_t e;
    logic signed [63:0] p, q, r;
    logic [63:0] pu;
    e.old_hi = h; e.old_lo = l; e.hi = h; e.lo = l; e.cyc = 0;
    $sformat(e.name, "op%0d_%h_%h", o, x, y);
    case (o)
      3'd0: begin
        p = longint'($signed(x)) * longint'($signed(y));
        e.hi = p[63:32]; e.lo = p[31:0]; e.cyc = MultN;
      end
      3'd1: begin
        pu = {32'h0, x} * {32'h0, y};
        e.hi = pu[63:32]; e.lo = pu[31:0]; e.cyc = MultN;
      end
      3'd2: begin
        e.cyc = DivN;
        if (y != 0) begin
          q = longint'($signed(x)) / longint'($signed(y));
          r = longint'($signed(x)) % longint'($signed(y));
          e.lo = q[31:0]; e.hi = r[31:0];
        end
      end
      3'd3: begin
        e.cyc = DivN;
        if (y != 0) begin
          e.lo = x / y; e.hi = x % y;
        end
      end
      3'd4: e.hi = x;
      3'd5: e.lo = x;
      default: ;
    endcase
    return e;
  endfunction

  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    exp_t e;
    int   guard = 0;
    @(negedge clk);
    while (busy && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    chk_int("issue_wait_idle", int'(busy), 0);
    e = model(o, x, y, m_hi, m_lo);
    m_hi = e.hi;
    m_lo = e.lo;
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = $urandom;
    b = $urandom;
    sb_q.push_back(e);
  endtask

  // Monitor: compares at each negedge once the DUT presents a result.
  logic bprev = 1'b0;
  int   bcnt = 0;
  int   age = 0;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        bprev = 1'b0; bcnt = 0; age = 0;
      end else begin
        if (busy) bcnt++;
        if (sb_q.size() == 0) begin
          chk_int("idle_busy", int'(busy), 0);
          bcnt = 0;
        end else begin
          e = sb_q[0];
          if (e.cyc == 0) begin
            chk_int({e.name, "_busy"}, int'(busy), 0);
            chk32({e.name, "_hi"}, hi, e.hi);
            chk32({e.name, "_lo"}, lo, e.lo);
            void'(sb_q.pop_front());
            age = 0;
          end else if (busy) begin
            chk32({e.name, "_hold_hi"}, hi, e.old_hi);
            chk32({e.name, "_hold_lo"}, lo, e.old_lo);
          end else if (bprev) begin
            chk_int({e.name, "_busy_cycles"}, bcnt, int'(e.cyc));
            chk32({e.name, "_hi"}, hi, e.hi);
            chk32({e.name, "_lo"}, lo, e.lo);
            void'(sb_q.pop_front());
            bcnt = 0; age = 0;
          end else begin
            age++;
            if (age > 2) begin
              chk_int({e.name, "_busy_rise"}, int'(busy), 1);
              void'(sb_q.pop_front());
              age = 0;
            end
          end
        end
        bprev = busy;
      end
    end
  end

  initial begin
    int guard;
    logic [2:0] ro;
    logic [31:0] rx, ry;

    // Reset state.
    repeat (2) @(negedge clk);
    chk_int("reset_busy", int'(busy), 0);
    chk32("reset_hi", hi, 32'h0);
    chk32("reset_lo", lo, 32'h0);
    reset = 1'b1;

    // Directed cases.
    issue(3'd0, 32'hFFFFFFFE, 32'h3);
    issue(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    issue(3'd2, 32'hFFFFFFF9, 32'h2);
    issue(3'd3, 32'hFFFFFFF9, 32'h2);
    issue(3'd2, 32'h80000000, 32'hFFFFFFFF);
    issue(3'd4, 32'h11, 32'h0);
    issue(3'd5, 32'h22, 32'h0);
    issue(3'd3, 32'h12345678, 32'h0);
    issue(3'd2, 32'h87654321, 32'h0);
    issue(3'd5, 32'h1234, 32'h0);
    issue(3'd6, 32'hDEAD, 32'hBEEF);
    issue(3'd7, 32'hDEAD, 32'hBEEF);

    // Start during a DIV run must be ignored.
    issue(3'd2, 32'd100, 32'd7);
    repeat (3) @(negedge clk);
    $display("note: protocol violation, start while busy (must be ignored)");
    start = 1'b1; op = 3'd0; a = 32'h7; b = 32'h9;
    @(posedge clk);
    #1;
    start = 1'b0;

    // Reset mid-DIV aborts the operation.
    issue(3'd2, 32'd1000, 32'd3);
    repeat (4) @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    sb_q.delete();
    m_hi = 32'h0;
    m_lo = 32'h0;
    chk_int("abort_busy", int'(busy), 0);
    chk32("abort_hi", hi, 32'h0);
    chk32("abort_lo", lo, 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (DivN + 4) @(negedge clk);
    chk32("post_abort_hi", hi, 32'h0);
    chk32("post_abort_lo", lo, 32'h0);

    // Randomised back-to-back traffic.
    for (int i = 0; i < 40; i++) begin
      ro = 3'($urandom_range(0, 7));
      rx = $urandom;
      ry = $urandom;
      case ($urandom_range(0, 7))
        0: ry = 32'h0;
        1: begin rx = 32'h80000000; ry = 32'hFFFFFFFF; end
        2: ry = 32'($urandom_range(1, 9));
        default: ;
      endcase
      issue(ro, rx, ry);
    end

    // Drain the scoreboard.
    guard = 0;
    while (sb_q.size() != 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    chk_int("drain_left", sb_q.size(), 0);
    @(negedge clk);
    chk32("final_hi", hi, m_hi);
    chk32("final_lo", lo, m_lo);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
